// File: rtl/mmio_io_pkg.sv
// mmio_io_pkg: shared constants for the MMIO button/LED hub.
//   Register offsets relative to BASE_ADDR, bit positions of the LED_CTRL
//   and EVENT fields, and the lowest-set-bit encoder used by EVENT reads.
package mmio_io_pkg;

    localparam int unsigned OFF_LED_CTRL = 0;
    localparam int unsigned OFF_EVENT    = 1;
    localparam int unsigned OFF_LEVEL    = 2;

    localparam int unsigned LED_MODE_BIT  = 16;
    localparam int unsigned LED_VAL_BIT   = 17;
    localparam int unsigned EVT_VALID_BIT = 31;
    localparam int unsigned EVT_OVF_BIT   = 30;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [3:0] lowest_idx(input logic [15:0] vec);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mmio_io_hub_if.sv
// mmio_io_hub_if: processor data-bus tap for the MMIO hub.
//   addr/wren/rden/data_in : driven by the bus master (CPU wrapper)
//   data_out/hit           : driven by the hub, combinational from addr
interface mmio_io_hub_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [ADDR_W-1:0] addr;
    logic              wren;
    logic              rden;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic              hit;

    modport master (output addr, wren, rden, data_in, input data_out, hit);
    modport slave  (input addr, wren, rden, data_in, output data_out, hit);
endinterface

// File: rtl/mmio_debounce.sv
// mmio_debounce: one button channel.
//   clock, reset (async, active-low)
//   raw   : asynchronous button level
//   level : debounced level
//   rise  : high during the cycle before level flips 0->1, so the event
//           lands in the pending register on the same edge as the level.
module mmio_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          flip;

    assign flip = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign rise = flip && !level;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/mmio_io_hub.sv
// mmio_io_hub: memory-mapped buttons and LEDs beside data RAM.
//   clock, reset : system clock, asynchronous active-low reset
//   bus          : data-bus slave port (addr/wren/rden/data_in in,
//                  data_out/hit out; wrapper muxes data_out when hit)
//   btn_in       : raw button levels, 1 = pressed
//   led          : LED drive, 1 = on
//   irq          : only when MMIO_IO_IRQ_EN is defined; registered |pending
// Registers: +0 LED_CTRL (wo), +1 EVENT (read-to-clear), +2 LEVEL (ro).
module mmio_io_hub
    import mmio_io_pkg::*;
#(
    parameter int unsigned       ADDR_W          = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR       = ADDR_W'(6),
    parameter int unsigned       N_BTN           = 4,
    parameter int unsigned       N_LED           = 4,
    parameter int unsigned       DEBOUNCE_CYCLES = 500000,
    parameter int unsigned       FLASH_CYCLES    = 12500000
) (
    input  logic             clock,
    input  logic             reset,
    mmio_io_hub_if.slave     bus,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_LED-1:0] led
`ifdef MMIO_IO_IRQ_EN
    ,
    output logic             irq
`endif
);
    localparam int unsigned TW = $clog2(FLASH_CYCLES + 1);

    // ---------------- address decode ----------------
    logic [ADDR_W-1:0] off;
    logic              sel_led, sel_evt, sel_lvl;

    assign off     = bus.addr - BASE_ADDR;
    assign bus.hit = (bus.addr >= BASE_ADDR) && (off <= ADDR_W'(OFF_LEVEL));
    assign sel_led = bus.hit && (off == ADDR_W'(OFF_LED_CTRL));
    assign sel_evt = bus.hit && (off == ADDR_W'(OFF_EVENT));
    assign sel_lvl = bus.hit && (off == ADDR_W'(OFF_LEVEL));

    // ---------------- button channels ----------------
    logic [N_BTN-1:0] level, rise;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        mmio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clock (clock),
            .reset (reset),
            .raw   (btn_in[g]),
            .level (level[g]),
            .rise  (rise[g])
        );
    end

    // ---------------- event capture ----------------
    logic [N_BTN-1:0] pending, clr, ovf_hits;
    logic             ovf, rd_evt, pend_any;
    logic [15:0]      pend16, lvl16, clr16;
    logic [3:0]       evt_idx;

    assign rd_evt   = bus.rden && sel_evt;
    assign pend_any = |pending;

    always_comb begin
        pend16 = '0;
        pend16[N_BTN-1:0] = pending;
        lvl16 = '0;
        lvl16[N_BTN-1:0] = level;
        evt_idx = lowest_idx(pend16);
        // Only the bit reported by this read is cleared.
        clr16 = '0;
        if (rd_evt && pend_any) clr16[evt_idx] = 1'b1;
        clr = clr16[N_BTN-1:0];
        // A rise on a bit still pending (and not being cleared now) is lost.
        ovf_hits = rise & pending & ~clr;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | rise;
            ovf     <= (ovf & ~(rd_evt && pend_any)) | (|ovf_hits);
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        bus.data_out = '0;
        if (sel_evt) begin
            bus.data_out[EVT_VALID_BIT] = pend_any;
            bus.data_out[EVT_OVF_BIT]   = ovf;
            bus.data_out[3:0]           = evt_idx;
        end else if (sel_lvl) begin
            bus.data_out[15:0] = lvl16;
        end
    end

    // ---------------- LEDs ----------------
    // A store that coincides with a load of the same register is dropped.
    logic wr_led, led_mode, led_val;

    assign wr_led   = bus.wren && sel_led && !bus.rden;
    assign led_mode = bus.data_in[LED_MODE_BIT];
    assign led_val  = bus.data_in[LED_VAL_BIT];

    for (genvar g = 0; g < N_LED; g++) begin : g_led
        logic          led_q;
        logic [TW-1:0] tmr;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                led_q <= 1'b0;
                tmr   <= '0;
            end else if (wr_led && bus.data_in[g]) begin
                led_q <= led_mode ? 1'b1 : led_val;
                tmr   <= led_mode ? TW'(FLASH_CYCLES) : '0;
            end else if (tmr != '0) begin
                tmr <= tmr - TW'(1);
                if (tmr == TW'(1)) led_q <= 1'b0;
            end
        end

        assign led[g] = led_q;
    end

`ifdef MMIO_IO_IRQ_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) irq <= 1'b0;
        else        irq <= pend_any;
    end
`endif

    // data_in bits outside the LED fields carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^bus.data_in;

endmodule

// File: tb/tb_mmio_io_hub.sv
module tb_mmio_io_hub;
    import mmio_io_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn_in;
    logic [3:0] led;
`ifdef MMIO_IO_IRQ_EN
    logic       irq;
`endif

    mmio_io_hub_if #(.ADDR_W(12)) bus ();

    mmio_io_hub #(
        .ADDR_W          (12),
        .BASE_ADDR       (12'd6),
        .N_BTN           (4),
        .N_LED           (4),
        .DEBOUNCE_CYCLES (4),
        .FLASH_CYCLES    (8)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus.slave),
        .btn_in (btn_in),
        .led    (led)
`ifdef MMIO_IO_IRQ_EN
        ,
        .irq    (irq)
`endif
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Load: expectation is queued as the strobe is driven, then popped and
    // compared against data_out before the clearing edge.
    task automatic rd(input logic [11:0] a, input logic [31:0] e, input string tag);
        exp_t x;
        bus.addr = a;
        bus.rden = 1'b1;
        sb.push_back('{tag: tag, val: e});
        #1;
        x = sb.pop_front();
        chk(x.tag, bus.data_out, x.val);
        @(negedge clock);
        bus.rden = 1'b0;
        bus.addr = 12'd0;
    endtask

    task automatic peek(input logic [11:0] a, input logic [31:0] e, input string tag);
        bus.addr = a;
        #1;
        chk(tag, bus.data_out, e);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic with_rd);
        bus.addr    = a;
        bus.data_in = d;
        bus.wren    = 1'b1;
        bus.rden    = with_rd;
        @(negedge clock);
        bus.wren = 1'b0;
        bus.rden = 1'b0;
        bus.addr = 12'd0;
    endtask

    task automatic flash_window(input string tag, input logic [3:0] on_val);
        for (int k = 0; k < 8; k++) begin
            chk(tag, 32'(led), 32'(on_val));
            tick(1);
        end
        chk({tag, "_off"}, 32'(led), 32'h0);
    endtask

    initial begin
        bus.addr    = 12'd0;
        bus.wren    = 1'b0;
        bus.rden    = 1'b0;
        bus.data_in = 32'h0;
        btn_in      = 4'b1111;

        // Reset state with all buttons held
        tick(3);
        chk("rst_led", 32'(led), 32'h0);
        peek(12'd7, 32'h0, "rst_event");
        peek(12'd8, 32'h0, "rst_level");
        bus.addr = 12'd7; #1; chk("rst_hit", 32'(bus.hit), 32'h1);
        btn_in = 4'b0000;
        tick(1);
        reset = 1'b1;
        tick(2);

        // Address decode boundaries
        bus.addr = 12'd5; #1; chk("hit_below", 32'(bus.hit), 32'h0);
        bus.addr = 12'd6; #1; chk("hit_base",  32'(bus.hit), 32'h1);
        bus.addr = 12'd8; #1; chk("hit_top",   32'(bus.hit), 32'h1);
        bus.addr = 12'd9; #1; chk("hit_above", 32'(bus.hit), 32'h0);
        tick(1);

        // Debounce: 3-cycle glitch rejected
        btn_in[2] = 1'b1; tick(3); btn_in[2] = 1'b0; tick(10);
        rd(12'd8, 32'h0, "glitch_level");
        rd(12'd7, 32'h0, "glitch_event");

        // Debounce: held press accepted exactly at cycle 6
        btn_in[2] = 1'b1;
        tick(5);
        peek(12'd8, 32'h0, "level_cycle5");
        tick(1);
        peek(12'd8, 32'h4, "level_cycle6");
        rd(12'd7, 32'h8000_0002, "event_btn2");
        btn_in[2] = 1'b0; tick(8);
        peek(12'd8, 32'h0, "level_release");
        rd(12'd7, 32'h0, "event_release");

        // Priority and clear
        btn_in = 4'b1010; tick(8);
        peek(12'd8, 32'hA, "level_b13");
        rd(12'd7, 32'h8000_0001, "prio_first");
        rd(12'd7, 32'h8000_0003, "prio_second");
        rd(12'd7, 32'h0,         "prio_third");
        btn_in = 4'b0000; tick(8);

        // Overflow
        btn_in[0] = 1'b1; tick(8);
        btn_in[0] = 1'b0; tick(8);
        btn_in[0] = 1'b1; tick(8);
        rd(12'd7, 32'hC000_0000, "ovf_first");
        rd(12'd7, 32'h0,         "ovf_second");
        btn_in[0] = 1'b0; tick(8);

        // Flash for exactly FLASH_CYCLES
        wr(12'd6, 32'h0001_0005, 1'b0);
        flash_window("flash", 4'b0101);

        // Retrigger at cycle 5
        wr(12'd6, 32'h0001_0005, 1'b0);
        tick(4);
        wr(12'd6, 32'h0001_0005, 1'b0);
        flash_window("retrig", 4'b0101);

        // Steady, unmasked LEDs untouched
        wr(12'd6, 32'h0002_0002, 1'b0);
        tick(10);
        chk("steady_on", 32'(led), 32'h2);
        wr(12'd6, 32'h0001_0001, 1'b0);
        chk("flash_led0_with_led1", 32'(led), 32'h3);
        tick(8);
        chk("unmasked_kept", 32'(led), 32'h2);

        // Store and load on LED_CTRL together: store dropped
        wr(12'd6, 32'h0002_0004, 1'b1);
        chk("wr_rd_same_reg", 32'(led), 32'h2);
        wr(12'd6, 32'h0000_0002, 1'b0);
        chk("steady_off", 32'(led), 32'h0);

        // Rise on the same edge as the read that clears that bit
        btn_in[0] = 1'b1; tick(8);
        btn_in[0] = 1'b0; tick(8);
        btn_in[0] = 1'b1;
        tick(5);
        rd(12'd7, 32'h8000_0000, "same_cycle_first");
        rd(12'd7, 32'h8000_0000, "same_cycle_second");
        rd(12'd7, 32'h0,         "same_cycle_third");
        btn_in[0] = 1'b0; tick(8);

        // Mid-operation asynchronous reset
        btn_in[3] = 1'b1; tick(8);
        wr(12'd6, 32'h0001_000F, 1'b0);
        chk("pre_rst_led", 32'(led), 32'hF);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_led", 32'(led), 32'h0);
        peek(12'd7, 32'h0, "midrst_event");
        peek(12'd8, 32'h0, "midrst_level");
        btn_in = 4'b0000;
        @(negedge clock);
        reset = 1'b1;
        tick(8);
        rd(12'd7, 32'h0, "post_rst_event");
        chk("post_rst_led", 32'(led), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
